seq_arith_16b_divmod: RTL and testbench

- Iterative unsigned divider. It inverts the 8-bit multiply-add datapath: given dividend = a*b + c, it recovers quotient and remainder against an 8-bit divisor.
- Restoring algorithm, one quotient bit per cycle.
- Latency-insensitive val/rdy streams on input and output.
- Used as a checker/recovery stage next to the comb multiply-add blocks in the arithmetic set.

---
 rtl/seq_arith_16b_divmod.sv | 105 ++++++++++
 tb/tb_seq_arith_16b_divmod.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_16b_divmod.sv
// Iterative 16b / 8b unsigned restoring divider with val/rdy streams.
// One quotient bit per cycle; the result is held in dedicated output registers.
module seq_arith_16b_divmod (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [15:0] istream_dividend,
  input  logic [7:0]  istream_divisor,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [15:0] ostream_quot,
  output logic [7:0]  ostream_rem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] quot_q,  quot_d;   // dividend bits shift out as quotient bits shift in
  logic [7:0]  dvs_q,   dvs_d;
  logic [16:0] rem_q,   rem_d;
  logic [15:0] res_quot_q, res_quot_d;
  logic [7:0]  res_rem_q,  res_rem_d;

  logic [16:0] shifted;
  logic        ge;

  // Bit 16 of the working remainder would be shifted out, so it forces a subtract.
  assign shifted = {rem_q[15:0], quot_q[15]};
  assign ge      = rem_q[16] | (shifted >= {9'd0, dvs_q});

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;

    unique case (state_q)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          quot_d  = istream_dividend;
          dvs_d   = istream_divisor;
          rem_d   = 17'd0;
          cnt_d   = 4'd15;
          state_d = CALC;
        end
      end

      CALC: begin
        rem_d  = ge ? (shifted - {9'd0, dvs_q}) : shifted;
        quot_d = {quot_q[14:0], ge};
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          res_quot_d = quot_d;
          res_rem_d  = rem_d[7:0];
          state_d    = DONE;
        end
      end

      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      quot_q     <= 16'd0;
      dvs_q      <= 8'd0;
      rem_q      <= 17'd0;
      res_quot_q <= 16'd0;
      res_rem_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
    end
  end

  assign ostream_quot = res_quot_q;
  assign ostream_rem  = res_rem_q;

endmodule

// File: tb/tb_seq_arith_16b_divmod.sv
// Self-checking bench for seq_arith_16b_divmod: directed cases then random
// requests against an arithmetic reference model.
module tb_seq_arith_16b_divmod;

  logic        clk = 1'b0;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [15:0] istream_dividend;
  logic [7:0]  istream_divisor;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [15:0] ostream_quot;
  logic [7:0]  ostream_rem;

  int tests = 0;
  int fails = 0;
  bit rdy_busy;

  seq_arith_16b_divmod dut (
    .clk              (clk),
    .reset            (reset),
    .istream_val      (istream_val),
    .istream_rdy      (istream_rdy),
    .istream_dividend (istream_dividend),
    .istream_divisor  (istream_divisor),
    .ostream_val      (ostream_val),
    .ostream_rdy      (ostream_rdy),
    .ostream_quot     (ostream_quot),
    .ostream_rem      (ostream_rem)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned division; divide-by-zero gives all-ones / dividend low byte.
  function automatic void ref_div(input logic [15:0] dvd, input logic [7:0] dvs,
                                  output logic [15:0] q, output logic [7:0] r);
    if (dvs == 8'd0) begin
      q = 16'hFFFF;
      r = dvd[7:0];
    end else begin
      q = dvd / {8'd0, dvs};
      r = 8'(dvd % {8'd0, dvs});
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] dvd, input logic [7:0] dvs);
    int n = 0;
    while (!istream_rdy && n < 50) begin @(negedge clk); n++; end
    check("send_rdy", {31'd0, istream_rdy}, 32'd1);
    istream_val = 1'b1;
    istream_dividend = dvd;
    istream_divisor = dvs;
    @(posedge clk);
    @(negedge clk);
    istream_val = 1'b0;
    istream_dividend = 16'($urandom);
    istream_divisor = 8'($urandom);
    check("busy_after_accept", {31'd0, istream_rdy}, 32'd0);
  endtask

  task automatic wait_val(output int lat);
    lat = 0;
    rdy_busy = 1'b0;
    while (!ostream_val && lat < 40) begin
      @(negedge clk);
      lat++;
      if (istream_rdy) rdy_busy = 1'b1;
    end
  endtask

  task automatic run_one(input string tag, input logic [15:0] dvd, input logic [7:0] dvs);
    int lat;
    logic [15:0] q;
    logic [7:0]  r;
    ref_div(dvd, dvs, q, r);
    send(dvd, dvs);
    wait_val(lat);
    check({tag, "_lat"}, lat, 32'd16);
    check({tag, "_quot"}, {16'd0, ostream_quot}, {16'd0, q});
    check({tag, "_rem"}, {24'd0, ostream_rem}, {24'd0, r});
    check({tag, "_rdy_busy"}, {31'd0, rdy_busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [15:0] q;
    logic [7:0]  r;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_r[$];
    logic [15:0] dvds[$];
    logic [7:0]  dvss[$];

    reset = 1'b0;
    istream_val = 1'b0;
    istream_dividend = 16'd0;
    istream_divisor = 8'd0;
    ostream_rdy = 1'b1;

    // 1: reset state, then 100 / 7
    repeat (2) @(negedge clk);
    check("rst_istream_rdy", {31'd0, istream_rdy}, 32'd1);
    check("rst_ostream_val", {31'd0, ostream_val}, 32'd0);
    check("rst_quot", {16'd0, ostream_quot}, 32'd0);
    check("rst_rem", {24'd0, ostream_rem}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    send(16'd100, 8'd7);
    wait_val(lat);
    check("t1_lat", lat, 32'd16);
    check("t1_quot", {16'd0, ostream_quot}, 32'd14);
    check("t1_rem", {24'd0, ostream_rem}, 32'd2);
    check("t1_rdy_busy", {31'd0, rdy_busy}, 32'd0);
    check("t1_rdy_done", {31'd0, istream_rdy}, 32'd0);
    @(negedge clk);
    check("t1_val_drop", {31'd0, ostream_val}, 32'd0);
    check("t1_rdy_back", {31'd0, istream_rdy}, 32'd1);
    check("t1_quot_hold", {16'd0, ostream_quot}, 32'd14);
    check("t1_rem_hold", {24'd0, ostream_rem}, 32'd2);

    // 2: inverses of multiply-add; 3: divide by zero
    run_one("t2a", 16'd65035, 8'd255);
    run_one("t2b", 16'd511, 8'd16);
    run_one("t2c", 16'd65535, 8'd1);
    run_one("t3_div0", 16'd10000, 8'd0);
    check("t3_rem_const", {24'd0, ostream_rem}, 32'h10);

    // 4: backpressure with a pending request held on the input
    ostream_rdy = 1'b0;
    send(16'd3780, 8'd90);
    wait_val(lat);
    check("t4_lat", lat, 32'd16);
    istream_val = 1'b1;
    istream_dividend = 16'd1000;
    istream_divisor = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_val_held", {31'd0, ostream_val}, 32'd1);
      check("t4_quot_held", {16'd0, ostream_quot}, 32'd42);
      check("t4_rem_held", {24'd0, ostream_rem}, 32'd0);
      check("t4_no_accept", {31'd0, istream_rdy}, 32'd0);
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    check("t4_val_after_xfer", {31'd0, ostream_val}, 32'd0);
    check("t4_bubble_rdy", {31'd0, istream_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    istream_val = 1'b0;
    check("t4_accepted", {31'd0, istream_rdy}, 32'd0);
    wait_val(lat);
    check("t4b_lat", lat, 32'd16);
    check("t4b_quot", {16'd0, ostream_quot}, 32'd333);
    check("t4b_rem", {24'd0, ostream_rem}, 32'd1);
    @(negedge clk);

    // 5: reset in the middle of CALC abandons the operation
    send(16'd1000, 8'd3);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_rst_val", {31'd0, ostream_val}, 32'd0);
    check("t5_rst_rdy", {31'd0, istream_rdy}, 32'd1);
    check("t5_rst_quot", {16'd0, ostream_quot}, 32'd0);
    check("t5_rst_rem", {24'd0, ostream_rem}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (ostream_val) seen = 1'b1;
    end
    check("t5_no_output", {31'd0, seen}, 32'd0);
    run_one("t5_clean", 16'd1000, 8'd3);

    // 6: random requests with random output backpressure
    for (int i = 0; i < 20; i++) begin
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [15:0] pq;
      logic [7:0]  pr;
      bit have_prev;
      bit done;
      int n;
      dvd = 16'($urandom);
      dvs = 8'($urandom_range(1, 255));
      ref_div(dvd, dvs, q, r);
      exp_q.push_back(q);
      exp_r.push_back(r);
      dvds.push_back(dvd);
      dvss.push_back(dvs);
      send(dvd, dvs);
      have_prev = 1'b0;
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
        if (have_prev) begin
          check("t6_val_stable", {31'd0, ostream_val}, 32'd1);
          check("t6_quot_stable", {16'd0, ostream_quot}, {16'd0, pq});
          check("t6_rem_stable", {24'd0, ostream_rem}, {24'd0, pr});
          have_prev = 1'b0;
        end
        ostream_rdy = 1'($urandom_range(0, 1));
        if (ostream_val) begin
          if (ostream_rdy) begin
            check("t6_quot", {16'd0, ostream_quot}, {16'd0, exp_q.pop_front()});
            check("t6_rem", {24'd0, ostream_rem}, {24'd0, exp_r.pop_front()});
            check("t6_identity",
                  {16'd0, ostream_quot} * {24'd0, dvss[0]} + {24'd0, ostream_rem},
                  {16'd0, dvds[0]});
            check("t6_rem_lt_dvs", {31'd0, ostream_rem < dvss[0]}, 32'd1);
            void'(dvds.pop_front());
            void'(dvss.pop_front());
            done = 1'b1;
          end else begin
            pq = ostream_quot;
            pr = ostream_rem;
            have_prev = 1'b1;
          end
        end
        @(negedge clk);
        n++;
      end
      check("t6_completed", {31'd0, done}, 32'd1);
    end
    check("t6_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
